// File: rtl/eth_pkg.sv
// Shared Ethernet RX types: default beat geometry, the stored beat layout
// and a saturating counter increment.
package eth_pkg;

  localparam int DATA_WIDTH = 512;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port beat storage: one write port, one read port whose output
// register only updates on rd_en_i, so it doubles as the stream output stage.
module eth_sdp_ram
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = BEAT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register is cleared by reset so a truncated output frame vanishes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/eth_rx_drop_fifo.sv
// Store-and-forward RX FIFO: frames become visible only at commit; frames
// flagged bad by tuser or that overflow the buffer are rolled back and counted.
module eth_rx_drop_fifo
  import eth_pkg::beat_t, eth_pkg::satInc;
#(
  parameter int DATA_WIDTH = eth_pkg::DATA_WIDTH,
  parameter int DEPTH      = 64
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [31:0]               drop_err_cnt,
  output logic [31:0]               drop_ovf_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] wrCommit_q, wrCommit_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   errCnt_q, errCnt_d;
  logic [31:0]   ovfCnt_q, ovfCnt_d;
  logic          sReady_q;
  logic          mValid_q, mValid_d;

  logic  full, accept, dropBeat, wrEn, rdEn;
  beat_t wrBeat, rdBeat;

  assign full     = (wrPtr_q - rdPtr_q) == PW'(DEPTH);
  assign accept   = s_axis_tvalid && sReady_q;
  assign dropBeat = ovf_q || full;
  assign wrEn     = accept && !dropBeat;
  assign rdEn     = (rdPtr_q != wrCommit_q) && (!mValid_q || m_axis_tready);

  assign wrBeat = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};

  // An overflowed frame is counted as overflow even when tuser also marks it bad.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    wrCommit_d = wrCommit_q;
    ovf_d      = ovf_q;
    errCnt_d   = errCnt_q;
    ovfCnt_d   = ovfCnt_q;
    if (accept) begin
      if (s_axis_tlast) begin
        wrPtr_d = wrCommit_q;
        ovf_d   = 1'b0;
        if (dropBeat) begin
          ovfCnt_d = satInc(ovfCnt_q);
        end else if (s_axis_tuser) begin
          errCnt_d = satInc(errCnt_q);
        end else begin
          wrPtr_d    = wrPtr_q + PW'(1);
          wrCommit_d = wrPtr_q + PW'(1);
        end
      end else if (dropBeat) begin
        ovf_d = 1'b1;
      end else begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
    end
  end

  // The RAM read register is the output stage; refill it whenever it empties or drains.
  always_comb begin
    rdPtr_d  = rdPtr_q + PW'(rdEn);
    mValid_d = mValid_q;
    if (rdEn) begin
      mValid_d = 1'b1;
    end else if (m_axis_tready) begin
      mValid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wrPtr_q    <= '0;
      wrCommit_q <= '0;
      rdPtr_q    <= '0;
      ovf_q      <= 1'b0;
      errCnt_q   <= '0;
      ovfCnt_q   <= '0;
      sReady_q   <= 1'b0;
      mValid_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      wrCommit_q <= wrCommit_d;
      rdPtr_q    <= rdPtr_d;
      ovf_q      <= ovf_d;
      errCnt_q   <= errCnt_d;
      ovfCnt_q   <= ovfCnt_d;
      sReady_q   <= 1'b1;
      mValid_q   <= mValid_d;
    end
  end

  eth_sdp_ram #(
    .DEPTH(DEPTH),
    .WIDTH($bits(beat_t))
  ) u_ram (
    .clk_i    (ap_clk),
    .rst_ni   (ap_rst_n),
    .wr_en_i  (wrEn),
    .wr_addr_i(wrPtr_q[AW-1:0]),
    .wr_data_i(wrBeat),
    .rd_en_i  (rdEn),
    .rd_addr_i(rdPtr_q[AW-1:0]),
    .rd_data_o(rdBeat)
  );

  assign s_axis_tready = sReady_q;
  assign m_axis_tvalid = mValid_q;
  assign m_axis_tdata  = rdBeat.data;
  assign m_axis_tkeep  = rdBeat.keep;
  assign m_axis_tlast  = rdBeat.last;
  assign drop_err_cnt  = errCnt_q;
  assign drop_ovf_cnt  = ovfCnt_q;
  assign fifo_level    = wrPtr_q - rdPtr_q;

endmodule

// File: tb/tb_eth_rx_drop_fifo.sv
// Directed bench for eth_rx_drop_fifo: a frame table plus hand-written
// overflow, stall-toggle, full-depth and mid-frame reset sequences.
module tb_eth_rx_drop_fifo;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } tbBeat_t;

  typedef struct {
    int nBeats;
    bit tuser;
    int tag;
    int expErr;
    int expOvf;
  } vec_t;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [31:0]   drop_err_cnt, drop_ovf_cnt;
  logic [6:0]    fifo_level;

  int      total = 0;
  int      bad   = 0;
  tbBeat_t expQ[$];
  tbBeat_t rxQ[$];
  bit      stallPrev = 0;
  tbBeat_t prevBeat;
  tbBeat_t curBeat;

  eth_rx_drop_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .drop_err_cnt (drop_err_cnt),
    .drop_ovf_cnt (drop_ovf_cnt),
    .fifo_level   (fifo_level)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic tbBeat_t mkBeat(int tag, int idx, bit last);
    tbBeat_t     b;
    logic [31:0] w;
    w = {tag[15:0], idx[15:0]};
    for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = w + 32'(k) * 32'h0101_0101;
    b.keep = {w, ~w};
    b.last = last;
    return b;
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checkBeat(string name, tbBeat_t act, tbBeat_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
               name, act.data, act.keep, act.last, exp.data, exp.keep, exp.last);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Output monitor: records every handshake and checks outputs hold while stalled.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stallPrev = 0;
    end else begin
      curBeat = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast};
      if (stallPrev) begin
        checkVal("stall_valid", m_axis_tvalid, 1);
        checkBeat("stall_hold", curBeat, prevBeat);
      end
      if (m_axis_tvalid && m_axis_tready) rxQ.push_back(curBeat);
      stallPrev = m_axis_tvalid && !m_axis_tready;
      prevBeat  = curBeat;
    end
  end

  task automatic applyStimulus(int n, bit tuser, int tag, bit good, bit safCheck);
    tbBeat_t b;
    for (int i = 0; i < n; i++) begin
      b = mkBeat(tag, i, i == n - 1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tuser  = tuser && b.last;
      if (good) expQ.push_back(b);
      tick();
      if (safCheck && i < n - 1) checkVal("store_fwd_hold", m_axis_tvalid, 0);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic checkOutput(string name, int expErr, int expOvf);
    int waitCnt;
    waitCnt = 0;
    while (rxQ.size() < expQ.size() && waitCnt < 500) begin
      tick();
      waitCnt++;
    end
    repeat (4) tick();
    checkVal({name, "_count"}, 64'(rxQ.size()), 64'(expQ.size()));
    while (expQ.size() > 0 && rxQ.size() > 0) checkBeat({name, "_beat"}, rxQ.pop_front(), expQ.pop_front());
    expQ.delete();
    rxQ.delete();
    checkVal({name, "_err_cnt"}, drop_err_cnt, 64'(expErr));
    checkVal({name, "_ovf_cnt"}, drop_ovf_cnt, 64'(expOvf));
    checkVal({name, "_level"}, fifo_level, 0);
    checkVal({name, "_idle"}, m_axis_tvalid, 0);
  endtask

  initial begin
    vec_t    vecs[5];
    tbBeat_t b;
    int      lat;

    vecs[0] = '{3, 1'b0, 'h10, 0, 0};
    vecs[1] = '{2, 1'b1, 'h20, 1, 0};
    vecs[2] = '{1, 1'b0, 'h30, 1, 0};
    vecs[3] = '{1, 1'b1, 'h40, 2, 0};
    vecs[4] = '{5, 1'b0, 'h50, 2, 0};

    ap_rst_n      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    checkVal("rst_s_tready", s_axis_tready, 0);
    checkVal("rst_m_tvalid", m_axis_tvalid, 0);
    checkVal("rst_level", fifo_level, 0);
    checkVal("rst_err_cnt", drop_err_cnt, 0);
    checkVal("rst_ovf_cnt", drop_ovf_cnt, 0);
    ap_rst_n = 1'b1;
    #1;
    checkVal("release_tready_low", s_axis_tready, 0);
    tick();
    checkVal("release_tready_high", s_axis_tready, 1);

    m_axis_tready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].nBeats, vecs[v].tuser, vecs[v].tag, !vecs[v].tuser, 1'b1);
      if (!vecs[v].tuser) begin
        lat = 0;
        while (!m_axis_tvalid && lat < 2) begin
          tick();
          lat++;
        end
        checkVal($sformatf("vec%0d_latency", v), m_axis_tvalid, 1);
      end
      checkOutput($sformatf("vec%0d", v), vecs[v].expErr, vecs[v].expOvf);
    end

    m_axis_tready = 1'b0;
    applyStimulus(DEPTH + 1, 1'b0, 'h90, 1'b0, 1'b1);
    tick();
    checkVal("ovf65_cnt", drop_ovf_cnt, 1);
    checkVal("ovf65_level", fifo_level, 0);
    checkVal("ovf65_idle", m_axis_tvalid, 0);
    applyStimulus(DEPTH + 2, 1'b1, 'h91, 1'b0, 1'b1);
    tick();
    checkVal("ovf_tuser_ovf_cnt", drop_ovf_cnt, 2);
    checkVal("ovf_tuser_err_cnt", drop_err_cnt, 2);
    applyStimulus(4, 1'b0, 'hA0, 1'b1, 1'b0);
    repeat (3) tick();
    checkVal("ovf_next_valid", m_axis_tvalid, 1);
    checkVal("ovf_nothing_emitted", 64'(rxQ.size()), 0);
    m_axis_tready = 1'b1;
    checkOutput("ovf_recover", 2, 2);

    m_axis_tready = 1'b0;
    applyStimulus(3, 1'b0, 'hB0, 1'b1, 1'b0);
    applyStimulus(4, 1'b0, 'hB1, 1'b1, 1'b0);
    for (int c = 0; c < 60 && rxQ.size() < expQ.size(); c++) begin
      m_axis_tready = !m_axis_tready;
      tick();
    end
    m_axis_tready = 1'b1;
    checkOutput("toggle", 2, 2);

    m_axis_tready = 1'b0;
    applyStimulus(DEPTH, 1'b0, 'hC0, 1'b1, 1'b0);
    checkVal("full_frame_level", fifo_level, 64);
    checkVal("full_frame_ovf_cnt", drop_ovf_cnt, 2);
    m_axis_tready = 1'b1;
    checkOutput("full_frame", 2, 2);

    m_axis_tready = 1'b0;
    applyStimulus(2, 1'b0, 'hD0, 1'b1, 1'b0);
    repeat (3) tick();
    checkVal("pre_reset_valid", m_axis_tvalid, 1);
    b = mkBeat('hD1, 0, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = 1'b0;
    tick();
    b = mkBeat('hD1, 1, 1'b0);
    s_axis_tdata = b.data;
    s_axis_tkeep = b.keep;
    ap_rst_n     = 1'b0;
    #1;
    checkVal("midrst_s_tready", s_axis_tready, 0);
    checkVal("midrst_m_tvalid", m_axis_tvalid, 0);
    checkVal("midrst_m_tlast", m_axis_tlast, 0);
    checkVal("midrst_level", fifo_level, 0);
    checkVal("midrst_err_cnt", drop_err_cnt, 0);
    checkVal("midrst_ovf_cnt", drop_ovf_cnt, 0);
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    checkVal("midrst_hold_tready", s_axis_tready, 0);
    expQ.delete();
    rxQ.delete();
    ap_rst_n = 1'b1;
    tick();
    checkVal("midrst_release_tready", s_axis_tready, 1);
    m_axis_tready = 1'b1;
    applyStimulus(3, 1'b0, 'hE0, 1'b1, 1'b1);
    checkOutput("post_reset", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
